serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 cin  input  1  carry-in; captured on an accepted start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  result, held from done until the next accepted start.
REQ-011 cout  output  1  final carry-out, held with sum.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE after WIDTH RUN cycles.
- DONE -> RUN if start is high; otherwise DONE -> IDLE.
REQ-013 A start SHALL be accepted only in IDLE or DONE.
- Accepting a start captures a, b and cin into internal shift and carry registers.
- Accepting a start clears the bit counter.
REQ-014 A start in RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-015 Each RUN cycle SHALL add one bit pair, LSB first, through one full-adder cell.
- Carry register updates with the cell carry.
- The sum bit shifts into sum from the MSB side.
- Operand registers shift right by one.
REQ-016 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap during a run.
REQ-017 RUN SHALL terminate when the counter reaches WIDTH-1.
REQ-018 done SHALL assert exactly WIDTH+1 rising edges after the edge that accepted start, for one cycle.
REQ-019 busy SHALL equal (state == RUN).
REQ-020 busy and done SHALL never be high together.
REQ-021 sum and cout SHALL be valid while done is high and SHALL remain stable until the next accepted start.
REQ-022 The result SHALL be modulo 2^WIDTH: {cout,sum} = a + b + cin.
REQ-023 While RUN is in progress, sum SHALL be treated as undefined by consumers; only done qualifies it.

Reset
REQ-024 Asserting rst at any time, including mid-run, SHALL within the same cycle:
- force state to IDLE;
- drive busy=0, done=0, sum=0, cout=0 (and ovf=0 when present);
- clear the counter, the operand registers and the carry register.
REQ-025 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 With SERIAL_ADDER_OVF_EN defined, the module SHALL add output ovf (1 bit): the signed two's-complement overflow of the run.
- ovf = carry into MSB XOR carry out of MSB.
- ovf is latched with sum and held under the same rules.
REQ-027 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 The shared package arith_pkg SHALL hold the FSM state encodings:
- IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the state width constant.
REQ-029 The bit cell SHALL be a separate sub-module, full_adder, built from two half_adder instances plus an OR gate.
REQ-030 serial_adder SHALL instantiate exactly one full_adder.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover these directed scenarios:
- a=0x00, b=0x00, cin=0, start -> done on the 9th edge; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0.
- a=0x7F, b=0x01, cin=0, macro defined -> sum=0x80, cout=0, ovf=1.
- Start with a=0x01, b=0x01; pulse start again with a=0xF0 at edge 3 -> second start ignored; sum=0x02.
- rst at edge 4 of a run -> busy=0, sum=0 immediately, no done.
- Back-to-back: start held high during the done cycle -> new run begins with no IDLE cycle.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: serial adder FSM encodings.
package arith_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder from two half adders and an OR.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .a (s1),
        .b (cin),
        .s (sum),
        .c (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, one bit pair per cycle, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             fs;
    logic             fc;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(WIDTH - 1));

    full_adder u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (c),
        .sum  (fs),
        .cout (fc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Accept and RUN are exclusive, so a start during RUN changes nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            rs  <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            ra  <= a;
            rb  <= b;
            c   <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            ra <= ra >> 1;
            rb <= rb >> 1;
            c  <= fc;
            rs <= {fs, rs[WIDTH-1:1]};
            if (!last) cnt <= cnt + 1'b1;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the MSB cycle c is the carry into the MSB and fc the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && last) begin
            ovf_q <= c ^ fc;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = rs;
    assign cout = c;

endmodule
